// File: rtl/butterfly_pair_serializer_if.sv
// Bus between the butterfly output, the pair serializer and the downstream stage:
// one complex pair in per transfer, one complex sample out per transfer.
interface butterfly_pair_serializer_if #(
    parameter int bit_width = 16
);
    logic signed [bit_width-1:0] Re_i1;
    logic signed [bit_width-1:0] Im_i1;
    logic signed [bit_width-1:0] Re_i2;
    logic signed [bit_width-1:0] Im_i2;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [bit_width-1:0] Re_o;
    logic signed [bit_width-1:0] Im_o;
    logic                        out_valid;
    logic                        out_ready;
    logic                        elem_sel;
    logic                        overflow;

    modport slave (
        input  Re_i1, Im_i1, Re_i2, Im_i2, in_valid, out_ready,
        output in_ready, Re_o, Im_o, out_valid, elem_sel, overflow
    );

    modport master (
        output Re_i1, Im_i1, Re_i2, Im_i2, in_valid, out_ready,
        input  in_ready, Re_o, Im_o, out_valid, elem_sel, overflow
    );
endinterface

// File: rtl/butterfly_pair_serializer.sv
// Buffers complex butterfly result pairs in a small FIFO and streams each pair
// out as two consecutive complex samples under valid/ready backpressure.
module butterfly_pair_serializer #(
    parameter int bit_width  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    butterfly_pair_serializer_if.slave  bus
);
    localparam int              PAIR_W    = 4 * bit_width;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    logic [PAIR_W-1:0]           mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]           wrPtr_q, rdPtr_q;
    logic [ADDR_W:0]             count_q, count_d;
    state_t                      state_q, state_d;
    logic signed [bit_width-1:0] reOut_q, reOut_d;
    logic signed [bit_width-1:0] imOut_q, imOut_d;
    logic signed [bit_width-1:0] holdRe_q, holdRe_d;
    logic signed [bit_width-1:0] holdIm_q, holdIm_d;
    logic                        outValid_q, outValid_d;
    logic                        elemSel_q, elemSel_d;
    logic                        overflow_q, overflow_d;

    logic                        full, empty, push, pop, loadHead;
    logic [PAIR_W-1:0]           headPair;
    logic signed [bit_width-1:0] headRe1, headIm1, headRe2, headIm2;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // Push is judged on the pre-edge full flag; a same-cycle pop never makes room.
    assign push       = bus.in_valid && !full;
    assign overflow_d = overflow_q || (bus.in_valid && full);

    assign headPair = mem_q[rdPtr_q];
    assign headRe1  = headPair[4*bit_width-1 -: bit_width];
    assign headIm1  = headPair[3*bit_width-1 -: bit_width];
    assign headRe2  = headPair[2*bit_width-1 -: bit_width];
    assign headIm2  = headPair[1*bit_width-1 -: bit_width];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        reOut_d    = reOut_q;
        imOut_d    = imOut_q;
        holdRe_d   = holdRe_q;
        holdIm_d   = holdIm_q;
        outValid_d = outValid_q;
        elemSel_d  = elemSel_q;
        loadHead   = 1'b0;

        case (state_q)
            IDLE: begin
                outValid_d = 1'b0;
                loadHead   = !empty;
            end
            FIRST: begin
                if (bus.out_ready) begin
                    reOut_d   = holdRe_q;
                    imOut_d   = holdIm_q;
                    elemSel_d = 1'b1;
                    state_d   = SECOND;
                end
            end
            SECOND: begin
                if (bus.out_ready) begin
                    if (!empty) begin
                        loadHead = 1'b1;
                    end else begin
                        outValid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                outValid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        // Element 2 waits in the holding register so the FIFO slot frees immediately.
        if (loadHead) begin
            reOut_d    = headRe1;
            imOut_d    = headIm1;
            holdRe_d   = headRe2;
            holdIm_d   = headIm2;
            elemSel_d  = 1'b0;
            outValid_d = 1'b1;
            state_d    = FIRST;
        end
    end

    assign pop = loadHead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            reOut_q    <= '0;
            imOut_q    <= '0;
            holdRe_q   <= '0;
            holdIm_q   <= '0;
            outValid_q <= 1'b0;
            elemSel_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_q + ADDR_W'(push);
            rdPtr_q    <= rdPtr_q + ADDR_W'(pop);
            count_q    <= count_d;
            state_q    <= state_d;
            reOut_q    <= reOut_d;
            imOut_q    <= imOut_d;
            holdRe_q   <= holdRe_d;
            holdIm_q   <= holdIm_d;
            outValid_q <= outValid_d;
            elemSel_q  <= elemSel_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {bus.Re_i1, bus.Im_i1, bus.Re_i2, bus.Im_i2};
        end
    end

    assign bus.in_ready  = !full;
    assign bus.Re_o      = reOut_q;
    assign bus.Im_o      = imOut_q;
    assign bus.out_valid = outValid_q;
    assign bus.elem_sel  = elemSel_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_butterfly_pair_serializer.sv
// Directed bench for butterfly_pair_serializer: ordering, latency, backpressure,
// overflow and asynchronous reset behaviour against hand-derived expectations.
module tb_butterfly_pair_serializer;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    butterfly_pair_serializer_if #(.bit_width(BW)) bus ();

    butterfly_pair_serializer #(
        .bit_width (BW),
        .FIFO_DEPTH(4),
        .ADDR_W    (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Pair idx of a test group: element e has Re = base + 16*idx + 2*e, Im = -Re - 1.
    function automatic int sampleRe(int base, int idx, int e);
        return base + 16 * idx + 2 * e;
    endfunction

    function automatic int sampleIm(int base, int idx, int e);
        return -(base + 16 * idx + 2 * e) - 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic valid, int re1, int im1, int re2, int im2, logic outReady);
        bus.in_valid  = valid;
        bus.Re_i1     = BW'(re1);
        bus.Im_i1     = BW'(im1);
        bus.Re_i2     = BW'(re2);
        bus.Im_i2     = BW'(im2);
        bus.out_ready = outReady;
    endtask

    task automatic applyPair(int base, int idx, logic valid, logic outReady);
        applyStimulus(valid, sampleRe(base, idx, 0), sampleIm(base, idx, 0),
                      sampleRe(base, idx, 1), sampleIm(base, idx, 1), outReady);
    endtask

    task automatic checkFlag(string tag, logic observed, logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkData(string tag, logic signed [BW-1:0] observed, logic signed [BW-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(string tag, logic expValid, int expRe, int expIm, logic expSel);
        checkFlag({tag, ".valid"}, bus.out_valid, expValid);
        checkData({tag, ".re"}, bus.Re_o, BW'(expRe));
        checkData({tag, ".im"}, bus.Im_o, BW'(expIm));
        checkFlag({tag, ".sel"}, bus.elem_sel, expSel);
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        $display("[TB] reset state");
        checkOutput("reset", 1'b0, 0, 0, 1'b0);
        checkFlag("reset.in_ready", bus.in_ready, 1'b1);
        checkFlag("reset.overflow", bus.overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("[TB] single pair");
        applyStimulus(1'b1, 100, -5, -200, 7, 1'b1);
        step();
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        checkFlag("t1.push.valid", bus.out_valid, 1'b0);
        step();
        checkOutput("t1.e1", 1'b1, 100, -5, 1'b0);
        step();
        checkOutput("t1.e2", 1'b1, -200, 7, 1'b1);
        step();
        checkFlag("t1.done.valid", bus.out_valid, 1'b0);
        checkData("t1.done.re_kept", bus.Re_o, BW'(-200));
        checkFlag("t1.done.in_ready", bus.in_ready, 1'b1);

        $display("[TB] back-to-back pairs");
        for (int c = 0; c < 10; c++) begin
            if (c < 8 && (c % 2) == 0) applyPair(1000, c / 2, 1'b1, 1'b1);
            else applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
            step();
            if (c >= 1 && c <= 8)
                checkOutput($sformatf("t2.s%0d", c - 1), 1'b1,
                            sampleRe(1000, (c - 1) / 2, (c - 1) % 2),
                            sampleIm(1000, (c - 1) / 2, (c - 1) % 2),
                            ((c - 1) % 2) == 1);
            else
                checkFlag($sformatf("t2.c%0d.valid", c), bus.out_valid, 1'b0);
        end
        checkFlag("t2.overflow", bus.overflow, 1'b0);

        $display("[TB] stall on element 2");
        applyStimulus(1'b1, 5, 6, -32768, 32767, 1'b1);
        step();
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        step();
        checkOutput("t4.e1", 1'b1, 5, 6, 1'b0);
        step();
        checkOutput("t4.e2", 1'b1, -32768, 32767, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("t4.hold%0d", i), 1'b1, -32768, 32767, 1'b1);
        end
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        step();
        checkFlag("t4.release.valid", bus.out_valid, 1'b0);

        $display("[TB] backpressure and overflow");
        for (int i = 0; i < 6; i++) begin
            applyPair(2000, i, 1'b1, 1'b0);
            step();
            if (i == 0) checkFlag("t3.p0.valid", bus.out_valid, 1'b0);
            else checkOutput($sformatf("t3.held%0d", i), 1'b1,
                             sampleRe(2000, 0, 0), sampleIm(2000, 0, 0), 1'b0);
            if (i == 3) checkFlag("t3.p3.in_ready", bus.in_ready, 1'b1);
            if (i == 4) begin
                checkFlag("t3.p4.in_ready", bus.in_ready, 1'b0);
                checkFlag("t3.p4.overflow", bus.overflow, 1'b0);
            end
        end
        checkFlag("t3.p5.overflow", bus.overflow, 1'b1);
        checkFlag("t3.p5.in_ready", bus.in_ready, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        for (int s = 1; s < 10; s++) begin
            step();
            checkOutput($sformatf("t3.s%0d", s), 1'b1,
                        sampleRe(2000, s / 2, s % 2), sampleIm(2000, s / 2, s % 2), (s % 2) == 1);
        end
        step();
        checkFlag("t3.drained.valid", bus.out_valid, 1'b0);

        $display("[TB] async reset mid-pair");
        applyPair(4000, 0, 1'b1, 1'b0);
        step();
        applyPair(4000, 1, 1'b1, 1'b0);
        step();
        applyPair(4000, 2, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        step();
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        checkOutput("t6.pre", 1'b1, sampleRe(4000, 0, 1), sampleIm(4000, 0, 1), 1'b1);
        checkFlag("t6.pre.overflow", bus.overflow, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6.rst", 1'b0, 0, 0, 1'b0);
        checkFlag("t6.rst.overflow", bus.overflow, 1'b0);
        checkFlag("t6.rst.in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 300, -300, 400, -400, 1'b1);
        step();
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        checkFlag("t6.push.valid", bus.out_valid, 1'b0);
        step();
        checkOutput("t6.e1", 1'b1, 300, -300, 1'b0);
        step();
        checkOutput("t6.e2", 1'b1, 400, -400, 1'b1);
        step();
        checkFlag("t6.done.valid", bus.out_valid, 1'b0);
        step();
        checkFlag("t6.stale.valid", bus.out_valid, 1'b0);

        $display("[TB] full with same-cycle pop");
        for (int i = 0; i < 5; i++) begin
            applyPair(3000, i, 1'b1, 1'b0);
            step();
        end
        checkFlag("t5.full.in_ready", bus.in_ready, 1'b0);
        checkOutput("t5.s0", 1'b1, sampleRe(3000, 0, 0), sampleIm(3000, 0, 0), 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        step();
        checkOutput("t5.s1", 1'b1, sampleRe(3000, 0, 1), sampleIm(3000, 0, 1), 1'b1);
        checkFlag("t5.s1.in_ready", bus.in_ready, 1'b0);
        checkFlag("t5.s1.overflow", bus.overflow, 1'b0);
        applyPair(3000, 5, 1'b1, 1'b1);
        step();
        checkFlag("t5.drop.overflow", bus.overflow, 1'b1);
        checkFlag("t5.drop.in_ready", bus.in_ready, 1'b1);
        checkOutput("t5.s2", 1'b1, sampleRe(3000, 1, 0), sampleIm(3000, 1, 0), 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        for (int s = 3; s < 10; s++) begin
            step();
            checkOutput($sformatf("t5.s%0d", s), 1'b1,
                        sampleRe(3000, s / 2, s % 2), sampleIm(3000, s / 2, s % 2), (s % 2) == 1);
        end
        step();
        checkFlag("t5.drained.valid", bus.out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
